// File: rtl/spram_pkg.sv
// Shared constants and sizing helpers for the single-port synchronous RAM.
// Optional build macro: SPRAM_MEM_CLEAR_EN (reset also clears the whole array).
package spram_pkg;

  localparam int SPRAM_ADDR_WIDTH = 16;
  localparam int SPRAM_DATA_WIDTH = 8;

  function automatic int spram_default_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  localparam int SPRAM_DEPTH = spram_default_depth(SPRAM_ADDR_WIDTH);

  // A one-word array still needs a 1-bit index.
  function automatic int spram_index_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/spram_if.sv
// Control bus of the single-port RAM: address, chip select, write/output enables,
// plus a status flag telling the master when the RAM is driving the data pins.
interface spram_if
  import spram_pkg::*;
#(
  parameter int ADDR_WIDTH = SPRAM_ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] addr;
  logic                  cs;
  logic                  we;
  logic                  oe;
  logic                  drive;

  modport master (output addr, cs, we, oe, input drive);
  modport slave  (input addr, cs, we, oe, output drive);

endinterface

// File: rtl/spram_array.sv
// Plain storage array: one write port and one registered read port, no tri-state.
// With SPRAM_MEM_CLEAR_EN defined, reset also zeroes every word asynchronously.
module spram_array
  import spram_pkg::*;
#(
  parameter int DATA_WIDTH  = SPRAM_DATA_WIDTH,
  parameter int DEPTH       = SPRAM_DEPTH,
  parameter int INDEX_WIDTH = spram_index_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [INDEX_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic                   re,
  input  logic                   rzero,
  input  logic [INDEX_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]  rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_d;
  logic [DATA_WIDTH-1:0] rd_q;

  // rzero substitutes 0 for reads the top has judged to be outside the array.
  always_comb begin
    rd_d = rd_q;
    if (re) begin
      rd_d = rzero ? '0 : mem[raddr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

`ifdef SPRAM_MEM_CLEAR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end
`else
  // Kept free of any reset so the array can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end
`endif

  assign rdata = rd_q;

endmodule

// File: rtl/single_port_sync_ram.sv
// Single-port synchronous RAM with a shared tri-state data bus (cs/we/oe control).
// Optional build macro: SPRAM_MEM_CLEAR_EN (reset also clears the array).
module single_port_sync_ram
  import spram_pkg::*;
#(
  parameter int ADDR_WIDTH = SPRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SPRAM_DATA_WIDTH,
  parameter int DEPTH      = spram_default_depth(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  spram_if.slave                bus,
  inout  wire  [DATA_WIDTH-1:0] data
);

  localparam int                  INDEX_WIDTH = spram_index_width(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

  logic                  in_range;
  logic                  mem_we;
  logic                  rd_en;
  logic                  drive_en;
  logic [DATA_WIDTH-1:0] rdata;

  // A write sharing the edge with reset is dropped; the bus is released while
  // writing so the external writer never sees contention.
  always_comb begin
    in_range = ({1'b0, bus.addr} < DEPTH_LIMIT);
    mem_we   = bus.cs & bus.we & in_range & ~rst;
    rd_en    = bus.cs & ~bus.we;
    drive_en = bus.cs & bus.oe & ~bus.we & ~rst;
  end

  spram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_we),
    .waddr(bus.addr[INDEX_WIDTH-1:0]),
    .wdata(data),
    .re   (rd_en),
    .rzero(~in_range),
    .raddr(bus.addr[INDEX_WIDTH-1:0]),
    .rdata(rdata)
  );

  assign bus.drive = drive_en;
  assign data      = drive_en ? rdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_single_port_sync_ram.sv
// Scoreboard bench for single_port_sync_ram: directed cases then random traffic,
// checked against an array-based model of the RAM's behaviour.
module tb_single_port_sync_ram;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 40;

  typedef struct {
    int            tag;
    logic [DW-1:0] value;
    bit            known;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          tb_drive;
  logic [DW-1:0] tb_wdata;
  wire  [DW-1:0] data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t exp_q[$];

  logic [DW-1:0] mem_m [DEPTH];
  bit            known_m [DEPTH];
  logic [DW-1:0] rd_m;
  bit            rd_known;

  assign data = tb_drive ? tb_wdata : {DW{1'bz}};

  spram_if #(.ADDR_WIDTH(AW)) bus ();

  single_port_sync_ram #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave),
    .data(data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic modelReset();
    rd_m     = '0;
    rd_known = 1'b1;
`ifdef SPRAM_MEM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i]   = '0;
      known_m[i] = 1'b1;
    end
`endif
  endtask

  // Effect of the coming rising edge given the inputs currently applied.
  task automatic modelEdge();
    int a;
    a = int'(bus.addr);
    if (rst) begin
      rd_m     = '0;
      rd_known = 1'b1;
    end else if (bus.cs && bus.we) begin
      if (a < DEPTH) begin
        mem_m[a]   = tb_wdata;
        known_m[a] = 1'b1;
      end
    end else if (bus.cs) begin
      if (a < DEPTH) begin
        rd_m     = mem_m[a];
        rd_known = known_m[a];
      end else begin
        rd_m     = '0;
        rd_known = 1'b1;
      end
    end
  endtask

  // Applies one cycle of inputs just after the falling edge and checks the
  // combinational bus response before the next rising edge.
  task automatic applyStimulus(input logic cs, input logic we, input logic oe,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    logic exp_drive;
    @(negedge clk);
    #1;
    bus.cs   = cs;
    bus.we   = we;
    bus.oe   = oe;
    bus.addr = addr;
    tb_wdata = wd;
    tb_drive = we;
    #1;
    exp_drive = cs & oe & ~we & ~rst;
    checkOutput("drive_now", 32'(bus.drive), 32'(exp_drive));
    if (exp_drive && rd_known) begin
      checkOutput("data_now", 32'(data), 32'(rd_m));
    end
    modelEdge();
    if (exp_drive) begin
      exp_q.push_back('{cyc + 1, rd_m, rd_known});
    end
  endtask

  // Raises oe shortly after a read edge that ran with oe low.
  task automatic lateEnable();
    @(posedge clk);
    #1;
    bus.oe = 1'b1;
    #1;
    checkOutput("late_oe_drive", 32'(bus.drive), 32'd1);
    if (rd_known) begin
      checkOutput("late_oe_data", 32'(data), 32'(rd_m));
    end
    exp_q.push_back('{cyc + 1, rd_m, rd_known});
  endtask

  // Short asynchronous reset pulse between edges while a read of addr is set up.
  task automatic pulseReset(input logic [AW-1:0] addr);
    @(negedge clk);
    #1;
    bus.cs   = 1'b1;
    bus.we   = 1'b0;
    bus.oe   = 1'b1;
    bus.addr = addr;
    tb_drive = 1'b0;
    rst      = 1'b1;
    #1;
    checkOutput("rst_pulse_drive", 32'(bus.drive), 32'd0);
    checkOutput("rst_pulse_rdq", 32'(dut.u_array.rd_q), 32'd0);
    modelReset();
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_release_drive", 32'(bus.drive), 32'd1);
    checkOutput("rst_release_data", 32'(data), 32'(rd_m));
    modelEdge();
    exp_q.push_back('{cyc + 1, rd_m, rd_known});
  endtask

  // Monitor: every falling edge the RAM either drives a scheduled read or stays off the bus.
  initial begin
    bit   has_exp;
    exp_t head;
    forever begin
      @(negedge clk);
      cyc++;
      has_exp = (exp_q.size() > 0) && (exp_q[0].tag == cyc);
      checks++;
      if (bus.drive !== has_exp) begin
        errors++;
        $display("[TB] FAIL bus_drive cycle %0d: drive=%0b, expected %0b", cyc, bus.drive, has_exp);
      end
      if (has_exp) begin
        head = exp_q.pop_front();
        if (bus.drive && head.known) begin
          checkOutput("read_data", 32'(data), 32'(head.value));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DW-1:0] wv;
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i]   = '0;
      known_m[i] = 1'b0;
    end
    rst      = 1'b1;
    bus.cs   = 1'b1;
    bus.we   = 1'b0;
    bus.oe   = 1'b1;
    bus.addr = '0;
    tb_drive = 1'b0;
    tb_wdata = '0;
    modelReset();

    #3;
    checkOutput("reset_drive", 32'(bus.drive), 32'd0);
    checkOutput("reset_rdq", 32'(dut.u_array.rd_q), 32'd0);
    @(negedge clk);
    #1;
    bus.cs = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b1, 6'd0, 8'h00);

    for (int a = 0; a < 16; a++) begin
      wv = (a == 3) ? 8'h24 : DW'($urandom);
      applyStimulus(1'b1, 1'b1, 1'b0, AW'(a), wv);
    end
    for (int a = 0; a < 16; a++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, AW'(a), 8'h00);
    end

    applyStimulus(1'b1, 1'b0, 1'b1, 6'd3, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd3, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd5, 8'h00);
    lateEnable();

    applyStimulus(1'b1, 1'b1, 1'b1, 6'd7, 8'hA5);
    applyStimulus(1'b1, 1'b0, 1'b1, 6'd7, 8'h00);

    applyStimulus(1'b1, 1'b1, 1'b0, 6'd9, 8'h5A);
    applyStimulus(1'b1, 1'b0, 1'b1, 6'd9, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'd9, 8'hFF);
    applyStimulus(1'b1, 1'b0, 1'b1, 6'd9, 8'h00);

    applyStimulus(1'b1, 1'b1, 1'b0, 6'd39, 8'hC3);
    applyStimulus(1'b1, 1'b1, 1'b0, 6'd45, 8'h77);
    applyStimulus(1'b1, 1'b0, 1'b1, 6'd39, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 6'd45, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 6'd5, 8'h00);

    applyStimulus(1'b1, 1'b1, 1'b0, 6'd2, 8'h3C);
    pulseReset(6'd2);
    applyStimulus(1'b1, 1'b0, 1'b1, 6'd2, 8'h00);

    for (int i = 0; i < 200; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) != 0, AW'($urandom_range(0, 47)), DW'($urandom));
    end

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
    end
    @(negedge clk);
    #1;
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
